trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning datapath and CSR width.
REQ-002 SHALL provide parameter FLUSH_CYCLES, default 2, meaning pipeline flush duration in cycles; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port ex_valid, input, 1 bit: the pipeline reports an exception this cycle.
REQ-006 SHALL have port ex_cause, input, 4 bits: exception code.
REQ-007 SHALL have port ex_pc, input, XLEN bits: pc of the faulting instruction.
REQ-008 SHALL have port sret_valid, input, 1 bit: an SRET instruction retires this cycle.
REQ-009 SHALL have port stvec, input, XLEN bits: trap vector base.
REQ-010 SHALL have port sepc_in, input, XLEN bits: current sepc value, used as the SRET return target.
REQ-011 SHALL have port csr_ack, input, 1 bit: the CSR unit accepts the write.
REQ-012 SHALL have port flush, output, 1 bit: squashes in-flight pipeline stages.
REQ-013 SHALL have port csr_we, output, 1 bit: CSR write request.
REQ-014 SHALL have port csr_scause, output, XLEN bits: value to be written to scause.
REQ-015 SHALL have port csr_sepc, output, XLEN bits: value to be written to sepc.
REQ-016 SHALL have port redirect_valid, output, 1 bit: fetch redirect strobe.
REQ-017 SHALL have port redirect_pc, output, XLEN bits: fetch redirect target.
REQ-018 SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, FLUSH, CSR_WR and REDIRECT.
REQ-020 SHALL, in IDLE when ex_valid=1, register cause and pc and go to FLUSH; ex_valid SHALL win over a simultaneous sret_valid.
REQ-021 SHALL, in IDLE when sret_valid=1 and ex_valid=0, register sepc_in as the target and go to FLUSH, marking the operation as SRET.
REQ-022 SHALL ignore ex_valid and sret_valid in every state other than IDLE, so events arriving while busy are dropped.
REQ-023 SHALL assert flush for exactly FLUSH_CYCLES consecutive cycles in FLUSH, counted by a down-counter loaded on entry, then go to CSR_WR for a trap or to REDIRECT for an SRET.
REQ-024 SHALL hold csr_we=1 with stable csr_scause and csr_sepc in CSR_WR until the cycle csr_ack=1, then go to REDIRECT; csr_ack outside CSR_WR SHALL be ignored.
REQ-025 SHALL set csr_scause = zero-extended ex_cause with bit XLEN-1 = 0.
REQ-026 SHALL set csr_sepc = registered ex_pc with bits [1:0] forced to 0.
REQ-027 SHALL drive redirect_valid for exactly one cycle in REDIRECT, with redirect_pc = {stvec[XLEN-1:2],2'b00} for a trap or the registered sepc_in with bits [1:0] forced to 0 for an SRET, then return to IDLE.
REQ-028 SHALL give trap latency as follows: ex_valid at cycle 0; flush during cycles 1..FLUSH_CYCLES; csr_we from cycle FLUSH_CYCLES+1; redirect_valid in the cycle after csr_ack.
REQ-029 SHALL sample stvec when entering REDIRECT, not when the exception is captured.
REQ-030 SHALL drive csr_we, flush and redirect_valid to 0 in every state where they are not specified as 1.

Reset
REQ-031 SHALL, when rst=1 on a clock edge, enter IDLE from any state, including mid-FLUSH and mid-CSR_WR, and abandon the operation.
REQ-032 SHALL clear after reset: flush, csr_we, redirect_valid and busy to 0; csr_scause, csr_sepc and redirect_pc to 0; the flush counter to 0.

Configuration
REQ-033 SHALL support macro TRAP_STVAL_EN; when it is defined, the block adds input ex_tval (XLEN), output csr_stval (XLEN), a register capturing ex_tval alongside ex_pc, and presents csr_stval under the same csr_we/csr_ack handshake; reset value 0.
REQ-034 SHALL, without TRAP_STVAL_EN, have neither port nor register and leave all other behaviour identical.

Structure
REQ-035 SHALL place the FSM state enum and the exception cause constants (INSTR_MISALIGNED=0, ILLEGAL_INSTR=2, BREAKPOINT=3, LOAD_FAULT=5, ECALL_U=8) in shared package trap_pkg.
REQ-036 SHALL keep the flush counter and FSM inline with no sub-module; the CSR unit consumes csr_we, csr_scause and csr_sepc directly.

Verification
REQ-037 SHALL cover a basic trap: ex_valid=1, ex_cause=2, ex_pc=0x0000_1006, stvec=0x8000_0101, ack on the first CSR_WR cycle -> flush high 2 cycles, csr_scause=0x2, csr_sepc=0x0000_1004, redirect_pc=0x8000_0100 for 1 cycle.
REQ-038 SHALL cover a delayed ack: csr_ack held low 3 cycles -> csr_we stays high 4 cycles with stable data; redirect follows the ack by 1 cycle.
REQ-039 SHALL cover simultaneous events: ex_valid=1 and sret_valid=1 in the same cycle -> trap path taken, no SRET redirect.
REQ-040 SHALL cover SRET: sret_valid=1, sepc_in=0x0000_2000 -> flush 2 cycles, csr_we never asserted, redirect_pc=0x0000_2000.
REQ-041 SHALL cover a busy drop: a second ex_valid during FLUSH -> ignored, and only one csr_we burst occurs.
REQ-042 SHALL cover reset mid-operation: rst in CSR_WR -> next cycle busy=0, csr_we=0, all outputs 0, and no redirect.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared trap-controller types: FSM state encoding and supervisor exception cause codes.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    CSR_WR   = 2'd2,
    REDIRECT = 2'd3
  } trap_state_t;

  localparam logic [3:0] INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] BREAKPOINT       = 4'd3;
  localparam logic [3:0] LOAD_FAULT       = 4'd5;
  localparam logic [3:0] ECALL_U          = 4'd8;

endpackage

// File: rtl/trap_ctrl.sv
// Supervisor trap/SRET sequencer: flush the pipeline, write scause/sepc, then redirect fetch.
// Optional macro TRAP_STVAL_EN adds ex_tval capture and a csr_stval output on the same handshake.
//
// Handshake: csr_we is a valid that stays high with stable csr_scause/csr_sepc
// until the cycle csr_ack (ready) is high; that cycle completes the transfer.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [3:0]      ex_cause,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            sret_valid,
  input  logic [XLEN-1:0] stvec,
  input  logic [XLEN-1:0] sepc_in,
  input  logic            csr_ack,
`ifdef TRAP_STVAL_EN
  input  logic [XLEN-1:0] ex_tval,
  output logic [XLEN-1:0] csr_stval,
`endif
  output logic            flush,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_scause,
  output logic [XLEN-1:0] csr_sepc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  output logic [1:0]      fsm_state
);

  trap_state_t     state;
  logic [3:0]      flush_cnt;
  logic            is_sret;
  logic [XLEN-1:0] sret_target;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      flush_cnt      <= 4'd0;
      is_sret        <= 1'b0;
      sret_target    <= '0;
      flush          <= 1'b0;
      csr_we         <= 1'b0;
      csr_scause     <= '0;
      csr_sepc       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
`ifdef TRAP_STVAL_EN
      csr_stval      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A trap outranks an SRET retiring in the same cycle.
          if (ex_valid) begin
            csr_scause <= {{(XLEN-4){1'b0}}, ex_cause};
            csr_sepc   <= {ex_pc[XLEN-1:2], 2'b00};
`ifdef TRAP_STVAL_EN
            csr_stval  <= ex_tval;
`endif
            is_sret    <= 1'b0;
            flush_cnt  <= 4'(FLUSH_CYCLES);
            flush      <= 1'b1;
            busy       <= 1'b1;
            state      <= FLUSH;
          end else if (sret_valid) begin
            sret_target <= {sepc_in[XLEN-1:2], 2'b00};
            is_sret     <= 1'b1;
            flush_cnt   <= 4'(FLUSH_CYCLES);
            flush       <= 1'b1;
            busy        <= 1'b1;
            state       <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd1) begin
            flush_cnt <= 4'd0;
            flush     <= 1'b0;
            if (is_sret) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= sret_target;
              state          <= REDIRECT;
            end else begin
              csr_we <= 1'b1;
              state  <= CSR_WR;
            end
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        CSR_WR: begin
          // stvec is sampled here so a handler base updated during the trap takes effect.
          if (csr_ack) begin
            csr_we         <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= {stvec[XLEN-1:2], 2'b00};
            state          <= REDIRECT;
          end
        end
        REDIRECT: begin
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          flush          <= 1'b0;
          csr_we         <= 1'b0;
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized scoreboard bench for trap_ctrl: drivers push expected CSR writes and redirects,
// a monitor pops and compares them whenever the DUT presents csr_we or redirect_valid.
module tb_trap_ctrl;
  import trap_pkg::*;

  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic [3:0]      ex_cause;
  logic [XLEN-1:0] ex_pc;
  logic            sret_valid;
  logic [XLEN-1:0] stvec;
  logic [XLEN-1:0] sepc_in;
  logic            csr_ack;
  logic            flush;
  logic            csr_we;
  logic [XLEN-1:0] csr_scause;
  logic [XLEN-1:0] csr_sepc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;
  logic [1:0]      fsm_state;
`ifdef TRAP_STVAL_EN
  logic [XLEN-1:0] ex_tval;
  logic [XLEN-1:0] csr_stval;
`endif

  int checks = 0;
  int fails  = 0;

  logic [2*XLEN-1:0] csr_q[$];
  logic [XLEN-1:0]   redir_q[$];

  trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_cause(ex_cause), .ex_pc(ex_pc),
    .sret_valid(sret_valid), .stvec(stvec), .sepc_in(sepc_in), .csr_ack(csr_ack),
`ifdef TRAP_STVAL_EN
    .ex_tval(ex_tval), .csr_stval(csr_stval),
`endif
    .flush(flush), .csr_we(csr_we), .csr_scause(csr_scause), .csr_sepc(csr_sepc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference helpers ----------------
  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] v);
    return v - (v % 4);
  endfunction

  function automatic logic [XLEN-1:0] cause_value(input logic [3:0] c);
    logic [XLEN-1:0] r;
    r = 0;
    r = r + c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [2*XLEN-1:0] cur_exp = '0;
  bit prev_we = 0;
  bit prev_rv = 0;
  int run_len = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_we = 0;
      prev_rv = 0;
      run_len = 0;
    end else begin
      chk("flush_we_exclusive", 64'(flush & csr_we), 0);
      if (csr_we) begin
        if (!prev_we) begin
          chk("csr_burst_expected", 64'(csr_q.size() != 0), 1);
          if (csr_q.size() != 0) cur_exp = csr_q.pop_front();
        end
        chk("csr_scause", csr_scause, cur_exp[2*XLEN-1:XLEN]);
        chk("csr_sepc", csr_sepc, cur_exp[XLEN-1:0]);
      end
      if (flush) run_len++;
      else if (run_len != 0) begin
        chk("flush_len", run_len, FC);
        run_len = 0;
      end
      if (redirect_valid) begin
        chk("redirect_expected", 64'(redir_q.size() != 0), 1);
        if (redir_q.size() != 0) chk("redirect_pc", redirect_pc, redir_q.pop_front());
        chk("redirect_one_cycle", 64'(prev_rv), 0);
      end
      prev_we = csr_we;
      prev_rv = redirect_valid;
    end
  end

  // ---------------- drivers ----------------
  task automatic run_op(input bit sret, input bit both, input logic [3:0] cause,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] sepc_v,
                        input logic [XLEN-1:0] stv0, input logic [XLEN-1:0] stv1,
                        input int ack_delay, input bit drop);
    int k;
    @(negedge clk);
    ex_valid   = !sret;
    sret_valid = sret | both;
    ex_cause   = cause;
    ex_pc      = pc;
    sepc_in    = sepc_v;
    stvec      = stv0;
    if (!sret) csr_q.push_back({cause_value(cause), align4(pc)});
    redir_q.push_back(sret ? align4(sepc_v) : align4(stv1));
    @(negedge clk);
    k = 1;
    ex_valid   = 1'b0;
    sret_valid = 1'b0;
    ex_pc      = $urandom;
    sepc_in    = $urandom;
    if (drop) begin
      ex_valid   = 1'b1;
      sret_valid = 1'($urandom_range(0, 1));
      ex_cause   = 4'($urandom_range(0, 15));
      @(negedge clk);
      k = 2;
      ex_valid   = 1'b0;
      sret_valid = 1'b0;
    end
    if (!sret) begin
      while (!csr_we && k < 40) begin
        csr_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        k++;
      end
      chk("trap_csr_latency", k, FC + 1);
      stvec = stv1;
      for (int d = 0; d <= ack_delay; d++) begin
        chk("csr_we_held", 64'(csr_we), 1);
        csr_ack = (d == ack_delay);
        @(negedge clk);
      end
      csr_ack = 1'b0;
      chk("redirect_after_ack", 64'(redirect_valid), 1);
    end else begin
      while (!redirect_valid && k < 40) begin
        csr_ack = 1'($urandom_range(0, 1));
        stvec   = $urandom;
        @(negedge clk);
        k++;
      end
      csr_ack = 1'b0;
      chk("sret_redirect_latency", k, FC + 1);
    end
    @(negedge clk);
    chk("idle_after_op", 64'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_flush"}, 64'(flush), 0);
    chk({tag, "_csr_we"}, 64'(csr_we), 0);
    chk({tag, "_redirect_valid"}, 64'(redirect_valid), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_csr_scause"}, csr_scause, 0);
    chk({tag, "_csr_sepc"}, csr_sepc, 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
  endtask

  task automatic reset_mid_op();
    int k;
    logic [3:0] c;
    logic [XLEN-1:0] p;
    c = 4'($urandom_range(0, 15));
    p = $urandom;
    @(negedge clk);
    ex_valid = 1'b1;
    ex_cause = c;
    ex_pc    = p;
    csr_q.push_back({cause_value(c), align4(p)});
    @(negedge clk);
    ex_valid = 1'b0;
    k = 1;
    while (!csr_we && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("reset_case_csr_latency", k, FC + 1);
    csr_ack = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("mid_reset");
    repeat (6) begin
      csr_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("no_redirect_after_reset", 64'(redirect_valid), 0);
    end
    csr_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] causes[5];

  initial begin
    causes = '{INSTR_MISALIGNED, ILLEGAL_INSTR, BREAKPOINT, LOAD_FAULT, ECALL_U};
    rst = 1'b1; ex_valid = 1'b0; ex_cause = '0; ex_pc = '0; sret_valid = 1'b0;
    stvec = '0; sepc_in = '0; csr_ack = 1'b0;
`ifdef TRAP_STVAL_EN
    ex_tval = '0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // basic trap, delayed ack, simultaneous events, SRET, busy drop
    run_op(0, 0, 4'd2, 32'h0000_1006, 32'h0, 32'h8000_0101, 32'h8000_0101, 0, 0);
    run_op(0, 0, 4'd5, 32'h0000_3003, 32'h0, 32'h4000_0000, 32'h4000_0204, 3, 0);
    run_op(0, 1, 4'd8, 32'h0000_4000, 32'h0000_7777, 32'h1234_5679, 32'h1234_5679, 1, 0);
    run_op(1, 0, 4'd0, 32'h0, 32'h0000_2000, 32'hdead_beef, 32'hdead_beef, 0, 0);
    run_op(0, 0, 4'd3, 32'h0000_5002, 32'h0, 32'h0000_0100, 32'h0000_0100, 2, 1);
    reset_mid_op();

    for (int i = 0; i < 40; i++) begin
      bit s, b, d;
      s = ($urandom_range(0, 3) == 0);
      b = !s && ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) == 0);
      run_op(s, b, causes[$urandom_range(0, 4)], $urandom, $urandom, $urandom, $urandom,
             $urandom_range(0, 4), d);
      if ($urandom_range(0, 9) == 0) reset_mid_op();
    end

    repeat (3) @(negedge clk);
    chk("csr_q_drained", csr_q.size(), 0);
    chk("redir_q_drained", redir_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
